m68k_bus_master: RTL and testbench
==================================

Name: m68k_bus_master

Overview:
- Initiator side of the 68000 asynchronous bus handshake that the C1 wait-state/nDTACK logic responds to.
- Accepts single-word read/write requests from a bench or sequencer and runs a full 68000-style bus cycle: S0–S7 states, nAS, nUDS/nLDS, RW.
- Inserts wait states while nDTACK is high, then returns read data and an acknowledge to the requester.
- Used as the CPU-side driver for exercising address decode, zone wait states and DTACK generation in simulation.

Parameters:
- TIMEOUT_WAITS, 64: number of wait cycles with nDTACK high before a bus error is flagged; only used with the optional feature.
- WCNT_W, 8: width of the per-cycle wait-state counter output.

Ports:
- CLK_68KCLK  in  1  state clock; one edge = one 68000 half-clock state (S0..S7); all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  1  request valid; sampled only in IDLE.
- REQ_RW  in  1  1 = read, 0 = write.
- REQ_ADDR  in  23  word address, A[23:1].
- REQ_WDATA  in  16  write data.
- REQ_BE  in  2  byte enables: [1] = upper byte (nUDS), [0] = lower byte (nLDS); 2'b00 is treated as 2'b11.
- ACK  out  1  one-clock pulse at cycle completion.
- BERR  out  1  one-clock pulse, coincident with ACK, when the cycle ended by timeout.
- RDATA  out  16  read data, held until the next read completes.
- WAIT_COUNT  out  WCNT_W  wait states inserted in the last completed cycle; saturates at all-ones.
- A  out  23  address bus.
- D_OUT  out  16  write data bus.
- D_OE  out  1  data bus drive enable.
- D_IN  in  16  read data bus.
- nAS, nUDS, nLDS  out  1 each  strobes, active low.
- RW  out  1  1 = read.
- nDTACK  in  1  data acknowledge, active low.

Behaviour:
- Reset values, applied one edge after RESET is high: state IDLE; nAS = nUDS = nLDS = 1; RW = 1; D_OE = 0; A = 0; D_OUT = 0; ACK = 0; BERR = 0; RDATA = 0; WAIT_COUNT = 0.
- RESET mid-cycle aborts immediately: strobes released on that edge, no ACK, no BERR.
- State sequence: IDLE → S0..S7 → IDLE.
- IDLE:
  - Strobes high; RW = 1; D_OE = 0.
  - If REQ is sampled high: latch address, RW, write data and enables; go to S0.
- S0: drive A and RW; clear the internal wait counter.
- S1: hold.
- S2: nAS = 0. For a read, the enabled nUDS/nLDS = 0. For a write, D_OE = 1 and D_OUT is driven.
- S3: for a write, the enabled data strobes = 0.
- S4: sample nDTACK.
  - nDTACK = 0 → S5.
  - nDTACK = 1 → enter wait pair W1, W2 (two clocks, one CPU clock), increment the wait counter, return to S4 and re-sample.
- S5: hold.
- S6: for a read, RDATA is loaded from D_IN on this edge.
- S7:
  - nAS, nUDS, nLDS = 1.
  - ACK = 1 for this clock only.
  - WAIT_COUNT is updated.
  - Next state is IDLE; D_OE = 0 and RW = 1 in IDLE.
- Latency: REQ sampled at edge t → ACK high in cycle t+8+2·waits. Back-to-back requests always have at least one IDLE clock between cycles.
- nDTACK is ignored outside S4.
- The wait counter is internal and unbounded up to TIMEOUT_WAITS; the WAIT_COUNT output saturates.

Optional Feature:
- Macro: M68K_BUS_TIMEOUT_EN.
- Defined:
  - When the wait count reaches TIMEOUT_WAITS while in S4 with nDTACK still high, go to S7.
  - ACK = 1 and BERR = 1 in that S7; RDATA is not updated.
- Undefined:
  - Waits indefinitely; BERR is tied to 0.

Decomposition:
- Shared package m68k_bus_pkg holds:
  - the state enum (IDLE, S0–S7, W1, W2);
  - the RW encoding constants;
  - the TIMEOUT_WAITS default.
- One natural sub-module: m68k_bus_watchdog, which holds the wait counter, the saturating WAIT_COUNT output and the timeout compare; it is instantiated only under the macro, with a tie-off otherwise.

Test Plan:
- Zero-wait read: nDTACK = 0 whenever nAS = 0, D_IN = 16'hA55A, REQ_ADDR = 23'h000100 → ACK 8 clocks after accept, RDATA = A55A, WAIT_COUNT = 0.
- One-wait read: a responder model holds nDTACK high for one CPU clock after nAS falls → ACK at 10 clocks, WAIT_COUNT = 1.
- Two-wait read: the same responder with two CPU clocks of delay → ACK at 12 clocks, WAIT_COUNT = 2.
- Byte write, REQ_BE = 01, WDATA = 16'h1234 → nLDS low from S3 to S7, nUDS stays high, D_OE = 1 from S2 until IDLE, D_OUT = 1234.
- Timeout (macro defined, TIMEOUT_WAITS = 4): nDTACK stuck high → ACK and BERR pulse together after 4 waits, RDATA unchanged.
- RESET asserted during W1 → next edge nAS = nUDS = nLDS = 1, D_OE = 0, state IDLE, no ACK. A subsequent REQ completes normally.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 bus master.
// State enum, RW encoding, timeout default, byte-enable helper.
package m68k_bus_pkg;

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7, W1, W2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int TIMEOUT_WAITS_DEF = 64;
  localparam int WCNT_INT_W        = 16;

  // No enables at all means a full word access.
  function automatic logic [1:0] norm_be(
    input logic [1:0] be
  );
    return (be == 2'b00) ? 2'b11 : be;
  endfunction

endpackage

// File: rtl/m68k_bus_watchdog.sv
// Wait-state counter, saturating WAIT_COUNT and timeout compare.
// Ports: i_clk/i_rst, i_clr/i_inc/i_upd controls, o_timeout, o_wait_count.
module m68k_bus_watchdog
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_WAITS = TIMEOUT_WAITS_DEF,
  parameter int WCNT_W        = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              i_upd,
  output logic              o_timeout,
  output logic [WCNT_W-1:0] o_wait_count
);

  localparam logic [WCNT_INT_W-1:0] LIMIT =
    WCNT_INT_W'(TIMEOUT_WAITS);
  localparam logic [WCNT_INT_W-1:0] SAT =
    WCNT_INT_W'({WCNT_W{1'b1}});

  logic [WCNT_INT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      o_wait_count <= '0;
    end else begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc && r_cnt != LIMIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_upd) begin
        if (r_cnt > SAT) o_wait_count <= '1;
        else o_wait_count <= r_cnt[WCNT_W-1:0];
      end
    end
  end

  assign o_timeout = (r_cnt >= LIMIT);

endmodule

// File: rtl/m68k_bus_master.sv
// 68000-style bus cycle initiator: S0..S7 with nDTACK wait pairs.
// Ports: REQ_* request in, ACK/BERR/RDATA/WAIT_COUNT out, A/D/strobes bus.
// Optional bus-error timeout: define M68K_BUS_TIMEOUT_EN.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_WAITS = TIMEOUT_WAITS_DEF,
  parameter int WCNT_W        = 8
) (
  input  logic              CLK_68KCLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              REQ_RW,
  input  logic [22:0]       REQ_ADDR,
  input  logic [15:0]       REQ_WDATA,
  input  logic [1:0]        REQ_BE,
  output logic              ACK,
  output logic              BERR,
  output logic [15:0]       RDATA,
  output logic [WCNT_W-1:0] WAIT_COUNT,
  output logic [22:0]       A,
  output logic [15:0]       D_OUT,
  output logic              D_OE,
  input  logic [15:0]       D_IN,
  output logic              nAS,
  output logic              nUDS,
  output logic              nLDS,
  output logic              RW,
  input  logic              nDTACK
);

  state_t      r_state;
  logic        r_rw;
  logic [22:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_be;
  logic        r_to;
  logic        r_ack;
  logic        r_berr;
  logic [15:0] r_rdata;
  logic [22:0] r_a;
  logic [15:0] r_dout;
  logic        r_doe;
  logic        r_nas;
  logic        r_nuds;
  logic        r_nlds;
  logic        r_rwo;

  logic              w_sample;
  logic              w_clr;
  logic              w_inc;
  logic              w_upd;
  logic              w_timeout;
  logic [WCNT_W-1:0] w_wait_count;

  // W2 closes a wait pair and re-samples nDTACK in place of S4,
  // so each wait costs exactly one CPU clock (two states).
  assign w_sample = (r_state == S4) || (r_state == W2);
  assign w_clr    = (r_state == S0);
  assign w_inc    = w_sample && nDTACK && !w_timeout;
  assign w_upd    = (r_state == S7);

`ifdef M68K_BUS_TIMEOUT_EN
  m68k_bus_watchdog #(
    .TIMEOUT_WAITS (TIMEOUT_WAITS),
    .WCNT_W        (WCNT_W)
  ) u_wdog (
    .i_clk        (CLK_68KCLK),
    .i_rst        (RESET),
    .i_clr        (w_clr),
    .i_inc        (w_inc),
    .i_upd        (w_upd),
    .o_timeout    (w_timeout),
    .o_wait_count (w_wait_count)
  );
`else
  localparam logic [WCNT_INT_W-1:0] SAT =
    WCNT_INT_W'({WCNT_W{1'b1}});

  logic [WCNT_INT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0]     r_wait_count;

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      r_wcnt       <= '0;
      r_wait_count <= '0;
    end else begin
      if (w_clr) begin
        r_wcnt <= '0;
      end else if (w_inc && r_wcnt != '1) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_upd) begin
        if (r_wcnt > SAT) r_wait_count <= '1;
        else r_wait_count <= r_wcnt[WCNT_W-1:0];
      end
    end
  end

  assign w_timeout    = 1'b0;
  assign w_wait_count = r_wait_count;
`endif

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_rw    <= RW_READ;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 2'b11;
      r_to    <= 1'b0;
      r_ack   <= 1'b0;
      r_berr  <= 1'b0;
      r_rdata <= '0;
      r_a     <= '0;
      r_dout  <= '0;
      r_doe   <= 1'b0;
      r_nas   <= 1'b1;
      r_nuds  <= 1'b1;
      r_nlds  <= 1'b1;
      r_rwo   <= RW_READ;
    end else begin
      r_ack  <= 1'b0;
      r_berr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_nas  <= 1'b1;
          r_nuds <= 1'b1;
          r_nlds <= 1'b1;
          r_rwo  <= RW_READ;
          r_doe  <= 1'b0;
          if (REQ) begin
            r_rw    <= REQ_RW;
            r_addr  <= REQ_ADDR;
            r_wdata <= REQ_WDATA;
            r_be    <= norm_be(REQ_BE);
            r_state <= S0;
          end
        end
        S0: begin
          r_a     <= r_addr;
          r_rwo   <= r_rw;
          r_to    <= 1'b0;
          r_state <= S1;
        end
        S1: r_state <= S2;
        S2: begin
          r_nas <= 1'b0;
          if (r_rw == RW_READ) begin
            r_nuds <= ~r_be[1];
            r_nlds <= ~r_be[0];
          end else begin
            r_doe  <= 1'b1;
            r_dout <= r_wdata;
          end
          r_state <= S3;
        end
        S3: begin
          if (r_rw == RW_WRITE) begin
            r_nuds <= ~r_be[1];
            r_nlds <= ~r_be[0];
          end
          r_state <= S4;
        end
        S4, W2: begin
          if (!nDTACK) begin
            r_state <= S5;
          end else if (w_timeout) begin
            r_to    <= 1'b1;
            r_state <= S7;
          end else begin
            r_state <= W1;
          end
        end
        W1: r_state <= W2;
        S5: r_state <= S6;
        S6: begin
          if (r_rw == RW_READ) r_rdata <= D_IN;
          r_state <= S7;
        end
        S7: begin
          r_nas   <= 1'b1;
          r_nuds  <= 1'b1;
          r_nlds  <= 1'b1;
          r_ack   <= 1'b1;
          r_berr  <= r_to;
          r_doe   <= 1'b0;
          r_rwo   <= RW_READ;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ACK        = r_ack;
  assign BERR       = r_berr;
  assign RDATA      = r_rdata;
  assign WAIT_COUNT = w_wait_count;
  assign A          = r_a;
  assign D_OUT      = r_dout;
  assign D_OE       = r_doe;
  assign nAS        = r_nas;
  assign nUDS       = r_nuds;
  assign nLDS       = r_nlds;
  assign RW         = r_rwo;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: vector table, scoreboard, corner sequences.
// Responder holds nDTACK high for a set number of CPU clocks.
module tb_m68k_bus_master;

  localparam int TW = 4;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          req_rw = 1'b1;
  logic [22:0]   req_addr = '0;
  logic [15:0]   req_wdata = '0;
  logic [1:0]    req_be = 2'b11;
  logic          ack, berr, d_oe;
  logic [15:0]   rdata, d_out;
  logic [15:0]   d_in = '0;
  logic [WW-1:0] wcount;
  logic [22:0]   a;
  logic          nas, nuds, nlds, rw;
  logic          ndtack;

  m68k_bus_master #(
    .TIMEOUT_WAITS (TW),
    .WCNT_W        (WW)
  ) dut (
    .CLK_68KCLK (clk),
    .RESET      (rst),
    .REQ        (req),
    .REQ_RW     (req_rw),
    .REQ_ADDR   (req_addr),
    .REQ_WDATA  (req_wdata),
    .REQ_BE     (req_be),
    .ACK        (ack),
    .BERR       (berr),
    .RDATA      (rdata),
    .WAIT_COUNT (wcount),
    .A          (a),
    .D_OUT      (d_out),
    .D_OE       (d_oe),
    .D_IN       (d_in),
    .nAS        (nas),
    .nUDS       (nuds),
    .nLDS       (nlds),
    .RW         (rw),
    .nDTACK     (ndtack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dk = 2 * CPU clocks of delay after nAS falls
  int   dk = 0;
  int   dcnt = 0;
  logic stuck = 1'b0;
  always @(posedge clk) begin
    if (nas !== 1'b0) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end
  assign ndtack = (stuck || nas !== 1'b0 || dcnt < dk);

  typedef struct {
    logic [15:0] rdata;
    logic [1:0]  wc;
    logic        berr;
    int          lat;
    int          t_acc;
    logic [22:0] addr;
  } exp_t;

  typedef struct {
    logic        rw;
    logic [22:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] din;
    int          dly;
    logic [15:0] exp_rd;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t v[6];
  int   tests = 0;
  int   fails = 0;
  int   n_acks = 0;
  int   exp_acks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic int sat_wc(input int w);
    return (w > 3) ? 3 : w;
  endfunction

  function automatic logic [1:0] nbe(input logic [1:0] be);
    return (be == 2'b00) ? 2'b11 : be;
  endfunction

  always @(negedge clk) begin
    if (!rst && ack === 1'b1) begin
      n_acks++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got 1 expected 0 cyc %0d",
                 cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rdata", rdata, mon_e.rdata);
        chk("wait_count", wcount, mon_e.wc);
        chk("berr", berr, mon_e.berr);
        chk("latency", cyc - 1 - mon_e.t_acc, mon_e.lat);
        chk("addr", a, mon_e.addr);
      end
    end else if (!rst && berr === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL berr_alone: got 1 expected 0 cyc %0d", cyc);
    end
  end

  task automatic issue(input logic rw_i,
                       input logic [22:0] ad,
                       input logic [15:0] wd,
                       input logic [1:0] be,
                       input exp_t e,
                       input logic push);
    @(negedge clk);
    req = 1'b1;
    req_rw = rw_i;
    req_addr = ad;
    req_wdata = wd;
    req_be = be;
    @(posedge clk);
    e.t_acc = cyc;
    if (push) begin
      sb.push_back(e);
      exp_acks++;
    end
    #1 req = 1'b0;
  endtask

  task automatic wait_acks();
    int b = 300;
    while (n_acks < exp_acks && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("ack_wait", n_acks, exp_acks);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stall expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [15:0] last_rd;
    int nk;

    v[0] = '{1'b1, 23'h000100, 16'h0000, 2'b11, 16'hA55A, 0, 16'hA55A};
    v[1] = '{1'b1, 23'h7FFFFF, 16'h0000, 2'b00, 16'h1357, 1, 16'h1357};
    v[2] = '{1'b1, 23'h000002, 16'h0000, 2'b10, 16'hFFFF, 2, 16'hFFFF};
    v[3] = '{1'b0, 23'h0ABCDE, 16'hBEEF, 2'b11, 16'h0000, 0, 16'hFFFF};
    v[4] = '{1'b1, 23'h123456, 16'h0000, 2'b01, 16'h0001, 4, 16'h0001};
    v[5] = '{1'b0, 23'h000000, 16'h5AA5, 2'b10, 16'h7777, 1, 16'h0001};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_nas", nas, 1);
    chk("rst_nuds", nuds, 1);
    chk("rst_nlds", nlds, 1);
    chk("rst_rw", rw, 1);
    chk("rst_doe", d_oe, 0);
    chk("rst_a", a, 0);
    chk("rst_dout", d_out, 0);
    chk("rst_ack", ack, 0);
    chk("rst_berr", berr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wcount", wcount, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      dk = 2 * v[i].dly;
      d_in = v[i].din;
      e = '{v[i].exp_rd, 2'(sat_wc(v[i].dly)), 1'b0,
            8 + 2 * v[i].dly, 0, v[i].addr};
      issue(v[i].rw, v[i].addr, v[i].wd, v[i].be, e, 1'b1);
      repeat (4) @(negedge clk);
      chk("s2_nas", nas, 0);
      chk("s2_rw", rw, v[i].rw);
      chk("s2_doe", d_oe, !v[i].rw);
      chk("s2_nuds", nuds, !(v[i].rw && nbe(v[i].be)[1]));
      chk("s2_nlds", nlds, !(v[i].rw && nbe(v[i].be)[0]));
      wait_acks();
    end
    last_rd = 16'h0001;

    dk = 0;
    d_in = 16'hCAFE;
    e = '{last_rd, 2'd0, 1'b0, 8, 0, 23'h000040};
    issue(1'b0, 23'h000040, 16'h1234, 2'b01, e, 1'b1);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("bw_nas", nas, !(k >= 3 && k <= 7));
        chk("bw_nuds", nuds, 1);
        chk("bw_nlds", nlds, !(k >= 4 && k <= 7));
        chk("bw_doe", d_oe, (k >= 3 && k <= 7));
        chk("bw_rw", rw, !(k >= 1 && k <= 7));
        if (k >= 3 && k <= 7) chk("bw_dout", d_out, 16'h1234);
      end
    end
    wait_acks();

`ifdef M68K_BUS_TIMEOUT_EN
    stuck = 1'b1;
    d_in = 16'hDEAD;
    e = '{last_rd, 2'(sat_wc(TW)), 1'b1, 6 + 2 * TW, 0, 23'h000200};
    issue(1'b1, 23'h000200, 16'h0000, 2'b11, e, 1'b1);
    wait_acks();
    stuck = 1'b0;
`endif

    stuck = 1'b1;
    issue(1'b1, 23'h000300, 16'h0000, 2'b11, e, 1'b0);
    repeat (6) @(negedge clk);
    chk("w1_nas_low", nas, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_nas", nas, 1);
    chk("abort_nuds", nuds, 1);
    chk("abort_nlds", nlds, 1);
    chk("abort_doe", d_oe, 0);
    chk("abort_ack", ack, 0);
    chk("abort_rw", rw, 1);
    chk("abort_rdata", rdata, 0);
    rst = 1'b0;
    stuck = 1'b0;
    nk = n_acks;
    repeat (20) @(negedge clk);
    chk("no_ack_after_abort", n_acks, nk);

    dk = 2;
    d_in = 16'h0F0F;
    e = '{16'h0F0F, 2'd1, 1'b0, 10, 0, 23'h000400};
    issue(1'b1, 23'h000400, 16'h0000, 2'b11, e, 1'b1);
    wait_acks();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
